// File: rtl/io_circuits_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_circuits_pkg
//  Description : Shared state encodings and timing constants for the button
//                input path (debouncer -> event generator -> MMIO/FIFO).
//  Revision    : 1.0  initial release
// ============================================================================
package io_circuits_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    // 1 ms tick at a 125 MHz system clock
    localparam int c_tick_1ms_125mhz = 125000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_gen_if
//  Description : Debounced level input and per-channel event outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface button_event_gen_if #(
    parameter int WIDTH = 1
) ();

    logic [WIDTH-1:0] debounced_in;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] long_pulse;
    logic [WIDTH-1:0] repeat_pulse;
    logic [WIDTH-1:0] held;

    modport master (
        output debounced_in,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  debounced_in,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );

endinterface
`default_nettype wire

// File: rtl/button_event_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_fsm
//  Description : One button channel: edge detect, press/long/repeat FSM,
//                tick counter and registered event outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module button_event_fsm
    import io_circuits_pkg::*;
#(
    parameter int HOLD_TICKS    = 500,
    parameter int REPEAT_TICKS  = 100,
    parameter int EVT_CNT_WIDTH = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS)) + 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic tick,
    input  wire logic din,
    output logic      press_pulse,
    output logic      release_pulse,
    output logic      long_pulse,
    output logic      repeat_pulse,
    output logic      held
);

    localparam int                       c_repeat_last_int = (REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1;
    localparam logic [EVT_CNT_WIDTH-1:0] c_hold_last       = EVT_CNT_WIDTH'(HOLD_TICKS - 1);
    localparam logic [EVT_CNT_WIDTH-1:0] c_repeat_last     = EVT_CNT_WIDTH'(c_repeat_last_int);
    localparam logic                     c_repeat_en       = (REPEAT_TICKS != 0);

    btn_state_t               r_state;
    btn_state_t               w_state_nxt;
    logic [EVT_CNT_WIDTH-1:0] r_cnt;
    logic [EVT_CNT_WIDTH-1:0] w_cnt_nxt;
    logic                     r_prev;
    logic                     w_rise;
    logic                     w_fall;

    logic r_press;
    logic r_release;
    logic r_long;
    logic r_repeat;
    logic r_held;
    logic w_press_nxt;
    logic w_release_nxt;
    logic w_long_nxt;
    logic w_repeat_nxt;

    assign w_rise = din & ~r_prev;
    assign w_fall = ~din & r_prev;

    // prev resets high so a button held through reset never reports a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_prev    <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_prev    <= din;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
            r_held    <= (w_state_nxt == ST_HELD);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end
            end

            // a release in the same cycle as the threshold tick takes priority
            ST_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else if (tick) begin
                    if (r_cnt == c_hold_last) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                        w_long_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            ST_HELD: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else if (tick && c_repeat_en) begin
                    if (r_cnt == c_repeat_last) begin
                        w_cnt_nxt    = '0;
                        w_repeat_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;
    assign held          = r_held;

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_gen
//  Description : Shared tick prescaler feeding WIDTH independent button event
//                channels (press, release, long-press, auto-repeat, held).
//  Revision    : 1.0  initial release
// ============================================================================
module button_event_gen
    import io_circuits_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int TICK_CNT_MAX   = c_tick_1ms_125mhz,
    parameter int HOLD_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100,
    parameter int TICK_CNT_WIDTH = $clog2(TICK_CNT_MAX) + 1,
    parameter int EVT_CNT_WIDTH  = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS)) + 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    button_event_gen_if.slave bus
);

    localparam logic [TICK_CNT_WIDTH-1:0] c_tick_last = TICK_CNT_WIDTH'(TICK_CNT_MAX - 1);

    logic [TICK_CNT_WIDTH-1:0] r_tick_cnt;
    logic                      w_tick;

    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;
    logic [WIDTH-1:0] w_long;
    logic [WIDTH-1:0] w_repeat;
    logic [WIDTH-1:0] w_held;

    // free-running from reset release; tick marks the last count of each period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == c_tick_last);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            button_event_fsm #(
                .HOLD_TICKS    (HOLD_TICKS),
                .REPEAT_TICKS  (REPEAT_TICKS),
                .EVT_CNT_WIDTH (EVT_CNT_WIDTH)
            ) u_fsm (
                .clk           (clk),
                .rst_n         (rst_n),
                .tick          (w_tick),
                .din           (bus.debounced_in[gi]),
                .press_pulse   (w_press[gi]),
                .release_pulse (w_release[gi]),
                .long_pulse    (w_long[gi]),
                .repeat_pulse  (w_repeat[gi]),
                .held          (w_held[gi])
            );
        end
    endgenerate

    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.long_pulse    = w_long;
    assign bus.repeat_pulse  = w_repeat;
    assign bus.held          = w_held;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_gen
//  Description : Self-checking bench for button_event_gen (table, directed
//                corner sequences and randomized stimulus vs. event model).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_event_gen;

    localparam int W   = 2;
    localparam int TCM = 4;
    localparam int HT  = 3;
    localparam int RT  = 2;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] p;
        logic [W-1:0] r;
        logic [W-1:0] l;
        logic [W-1:0] rp;
        logic [W-1:0] h;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din   = '0;
    int           total = 0;
    int           bad   = 0;

    vec_t         tbl[12];

    // reference model state: press is "active" and counts ticks since press
    bit           m_active[W];
    int           m_ticks[W];
    logic [W-1:0] m_prev;
    logic [W-1:0] ep, er, el, erp, eh;
    logic [5*W-1:0] expv;

    button_event_gen_if #(.WIDTH(W)) bif ();
    assign bif.debounced_in = din;

    button_event_gen #(
        .WIDTH        (W),
        .TICK_CNT_MAX (TCM),
        .HOLD_TICKS   (HT),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [5*W-1:0] pk(input logic [W-1:0] p, input logic [W-1:0] r,
                                          input logic [W-1:0] l, input logic [W-1:0] rp,
                                          input logic [W-1:0] h);
        return {p, r, l, rp, h};
    endfunction

    task automatic chk(input string nm, input int c, input logic [5*W-1:0] exp);
        logic [5*W-1:0] act;
        act = {bif.press_pulse, bif.release_pulse, bif.long_pulse, bif.repeat_pulse, bif.held};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got press/rel/long/rep/held=%b want=%b", nm, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // leaves the bench at the negedge just before cycle 0
    task automatic reset_dut(input logic [W-1:0] d);
        @(negedge clk);
        rst_n = 1'b0;
        din   = d;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state", 0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //               din    press  rel    long   rep    held
        tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[4]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[5]  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

        // short presses on both channels
        reset_dut('0);
        for (int c = 0; c < 12; c++) begin
            din = tbl[c].din;
            chk("short_press", c, pk(tbl[c].p, tbl[c].r, tbl[c].l, tbl[c].rp, tbl[c].h));
            step();
        end

        // long press with auto-repeat, released in cycle 30
        reset_dut('0);
        for (int c = 0; c < 35; c++) begin
            din = {1'b0, (c >= 1 && c <= 29)};
            chk("long_repeat", c, pk({1'b0, c == 2}, {1'b0, c == 31}, {1'b0, c == 12},
                                     {1'b0, (c == 20 || c == 28)}, {1'b0, (c >= 12 && c <= 30)}));
            step();
        end

        // release lands on the threshold tick: release wins, no long press
        reset_dut('0);
        for (int c = 0; c < 21; c++) begin
            din = {1'b0, (c >= 1 && c <= 10)};
            chk("fall_vs_threshold", c, pk({1'b0, c == 2}, {1'b0, c == 12}, '0, '0, '0));
            step();
        end

        // held through reset: no press, release ignored, re-press reported
        reset_dut(2'b01);
        for (int c = 0; c < 16; c++) begin
            din = {1'b0, (c < 4 || c >= 8)};
            chk("held_thru_reset", c, pk({1'b0, c == 9}, '0, '0, '0, '0));
            step();
        end

        // channel independence, then asynchronous reset mid-operation
        reset_dut('0);
        for (int c = 0; c < 17; c++) begin
            din = {(c >= 13), (c >= 1)};
            chk("independence", c, pk({c == 14, c == 2}, '0, {1'b0, c == 12}, '0,
                                      {1'b0, c >= 12}));
            if (c < 16) step();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_reset_async", 16, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            din = (c < 4) ? 2'b11 : ((c < 6) ? 2'b00 : 2'b10);
            chk("after_mid_reset", c, pk({c == 7, 1'b0}, '0, '0, '0, '0));
            step();
        end

        // randomized levels against the event model
        reset_dut('0);
        m_prev = '1;
        expv   = '0;
        for (int i = 0; i < W; i++) begin
            m_active[i] = 1'b0;
            m_ticks[i]  = 0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(15) == 0) din[i] = ~din[i];
            end
            chk("random", c, expv);
            ep = '0; er = '0; el = '0; erp = '0; eh = '0;
            for (int i = 0; i < W; i++) begin
                if (!m_active[i]) begin
                    if (din[i] && !m_prev[i]) begin
                        ep[i]       = 1'b1;
                        m_active[i] = 1'b1;
                        m_ticks[i]  = 0;
                    end
                end else if (!din[i] && m_prev[i]) begin
                    er[i]       = 1'b1;
                    m_active[i] = 1'b0;
                end else if ((c % TCM) == TCM - 1) begin
                    if (m_ticks[i] < HT) begin
                        m_ticks[i]++;
                        if (m_ticks[i] == HT) el[i] = 1'b1;
                    end else if (RT != 0) begin
                        m_ticks[i]++;
                        if (((m_ticks[i] - HT) % RT) == 0) erp[i] = 1'b1;
                    end
                end
                eh[i] = m_active[i] && (m_ticks[i] >= HT);
            end
            expv   = pk(ep, er, el, erp, eh);
            m_prev = din;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
